// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared types for the note block loader
// Contents: NOTE_W (default note word width), note_t (one note word),
//           loader_state_t (loader FSM states).
package note_pkg;

    localparam int NOTE_W = 16;

    typedef logic [NOTE_W-1:0] note_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } loader_state_t;

endpackage

// File: rtl/read_tag_pipe.sv
// rtl/read_tag_pipe.sv - LATENCY-deep {valid, idx} delay line matching BRAM read latency
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   flush_i        synchronous clear of every in-flight token
//   valid_i/idx_i  token entering alongside an issued read address
//   valid_o/idx_o  token emerging in the same cycle as its read data
//   pending_o      a token is still travelling in a stage other than the output stage
module read_tag_pipe #(
    parameter int LATENCY = 2,
    parameter int IDX_W   = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             pending_o
);

    logic [LATENCY-1:0]            valid_q;
    logic [LATENCY-1:0][IDX_W-1:0] idx_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            idx_q   <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            idx_q[0]   <= idx_i;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign idx_o   = idx_q[LATENCY-1];

    // The output-stage token lands on the coming edge, so only earlier
    // stages still hold reads that have not been captured.
    always_comb begin
        pending_o = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
            pending_o = pending_o | valid_q[i];
        end
    end

endmodule

// File: rtl/note_block_loader.sv
// rtl/note_block_loader.sv - fetches a block of notes from a synchronous BRAM into a register array
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start, abort    load request (taken when not busy), cancel of a running load
//   base_addr,count first BRAM address and block length, sampled on an accepted start
//   mem_addr        BRAM read address; mem_rdata arrives READ_LATENCY cycles later
//   notes           slot i = BRAM[base_addr+i]
//   note_valid      bit i set once slot i was written in this load
//   loaded_count    slots written in the current/last load
//   busy, done      issuing/draining; block complete until next accepted start
module note_block_loader
    import note_pkg::*;
#(
    parameter int DATA_W       = NOTE_W,
    parameter int ADDR_W       = 9,
    parameter int NUM_NOTES    = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                abort,
    input  logic [ADDR_W-1:0]                   base_addr,
    input  logic [$clog2(NUM_NOTES+1)-1:0]      count,
    output logic [ADDR_W-1:0]                   mem_addr,
    input  logic [DATA_W-1:0]                   mem_rdata,
    output logic [NUM_NOTES-1:0][DATA_W-1:0]    notes,
    output logic [NUM_NOTES-1:0]                note_valid,
    output logic [$clog2(NUM_NOTES+1)-1:0]      loaded_count,
    output logic                                busy,
    output logic                                done
);

    localparam int CNT_W = $clog2(NUM_NOTES + 1);
    localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_NOTES);

    loader_state_t               state_q, state_d;
    logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            k_q, k_d;
    logic [NUM_NOTES-1:0][DATA_W-1:0] notes_q;
    logic [NUM_NOTES-1:0]        note_valid_q;
    logic [CNT_W-1:0]            loaded_count_q;

    logic             accept;
    logic             issue_valid;
    logic             flush;
    logic [CNT_W-1:0] count_clamped;
    logic             tag_valid;
    logic [IDX_W-1:0] tag_idx;
    logic             tag_pending;

    assign count_clamped = (count > MAX_CNT) ? MAX_CNT : count;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        accept      = 1'b0;
        issue_valid = 1'b0;
        flush       = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept = 1'b1;
                    cnt_d  = count_clamped;
                    k_d    = '0;
                    if (count_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        mem_addr_d = base_addr;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else begin
                    issue_valid = 1'b1;
                    if ((CNT_W'(k_q) + CNT_W'(1)) == cnt_q) begin
                        state_d = DRAIN;
                    end else begin
                        k_d        = k_q + IDX_W'(1);
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (!tag_pending) begin
                    // Last token may be landing this very edge; done rises with it.
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    read_tag_pipe #(
        .LATENCY (READ_LATENCY),
        .IDX_W   (IDX_W)
    ) u_tag_pipe (
        .clk_i     (clk),
        .rst_i     (reset),
        .flush_i   (flush),
        .valid_i   (issue_valid),
        .idx_i     (k_q),
        .valid_o   (tag_valid),
        .idx_o     (tag_idx),
        .pending_o (tag_pending)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            mem_addr_q     <= '0;
            cnt_q          <= '0;
            k_q            <= '0;
            notes_q        <= '0;
            note_valid_q   <= '0;
            loaded_count_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            if (accept) begin
                note_valid_q   <= '0;
                loaded_count_q <= '0;
            end else if (tag_valid && !flush) begin
                notes_q[tag_idx]      <= mem_rdata;
                note_valid_q[tag_idx] <= 1'b1;
                loaded_count_q        <= loaded_count_q + CNT_W'(1);
            end
        end
    end

    assign mem_addr     = mem_addr_q;
    assign notes        = notes_q;
    assign note_valid   = note_valid_q;
    assign loaded_count = loaded_count_q;
    assign busy         = (state_q == ISSUE) || (state_q == DRAIN);
    assign done         = (state_q == DONE);

endmodule
